// File: rtl/rst_seq_pkg.sv
// Shared types for the staged reset sequencer.
// State and cause encodings plus a small sizing helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        PERIPH = 2'd1,
        DSP    = 2'd2,
        RUN    = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        CAUSE_HARD = 2'b00,
        CAUSE_SOFT = 2'b01,
        CAUSE_WDOG = 2'b10
    } rst_cause_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sequencer_wdog.sv
// Watchdog down-counter for the reset sequencer.
// Reload wins over counting; expired flags a zero count.
module rst_wdog #(
    parameter int WDOG_W = 24
) (
    input  logic clk_54,
    input  logic final_rst,
    input  logic reload,
    input  logic enable,
    output logic expired
);

    logic [WDOG_W-1:0] cnt_q;

    // Reload to all-ones, otherwise count down while enabled
    always_ff @(posedge clk_54 or posedge final_rst) begin
        if (final_rst) begin
            cnt_q <= '1;
        end else if (reload) begin
            cnt_q <= '1;
        end else if (enable) begin
            cnt_q <= cnt_q - WDOG_W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: stretch, then periph -> dsp -> cpu release.
// Soft request and watchdog expiry both re-run the whole sequence.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int STRETCH_CYC = 16,
    parameter int STAGE_GAP   = 8,
    parameter int WDOG_W      = 24
) (
    input  logic       clk_54,
    input  logic       final_rst,
    input  logic       soft_rst_req,
    output logic       soft_rst_ack,
    input  logic       wdog_en,
    input  logic       wdog_kick,
    output logic       rst_n_periph,
    output logic       rst_n_dsp,
    output logic       rst_n_cpu,
    output logic [1:0] rst_cause,
    output logic       seq_busy
);

    localparam int CNT_W =
        $clog2(max_int(STRETCH_CYC, STAGE_GAP)) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'(STRETCH_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST =
        CNT_W'(STAGE_GAP - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rst_cause_t       cause_q, cause_d;
    logic             ack_d;
    logic             in_run;
    logic             wdog_expired;
    logic             wdog_fire;

    assign in_run = (state_q == RUN);

    // Reloaded outside RUN, when disabled, or when kicked
    rst_wdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk_54    (clk_54),
        .final_rst (final_rst),
        .reload    (wdog_kick | ~wdog_en | ~in_run),
        .enable    (in_run & wdog_en),
        .expired   (wdog_expired)
    );

    // A kick in the expiry cycle suppresses the reset
    assign wdog_fire = in_run & wdog_en & ~wdog_kick & wdog_expired;

    // Next-state, stage counter and cause/ack decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        cause_d = cause_q;
        ack_d   = 1'b0;
        unique case (state_q)
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = PERIPH;
                    cnt_d   = '0;
                end
            end
            PERIPH: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = DSP;
                    cnt_d   = '0;
                end
            end
            DSP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (soft_rst_req) begin
                    state_d = HOLD;
                    cause_d = CAUSE_SOFT;
                    ack_d   = 1'b1;
                end else if (wdog_fire) begin
                    state_d = HOLD;
                    cause_d = CAUSE_WDOG;
                end
            end
        endcase
    end

    // State and every output are single flops fed from next state
    always_ff @(posedge clk_54 or posedge final_rst) begin
        if (final_rst) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            cause_q      <= CAUSE_HARD;
            soft_rst_ack <= 1'b0;
            rst_n_periph <= 1'b0;
            rst_n_dsp    <= 1'b0;
            rst_n_cpu    <= 1'b0;
            seq_busy     <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cause_q      <= cause_d;
            soft_rst_ack <= ack_d;
            rst_n_periph <= (state_d != HOLD);
            rst_n_dsp    <= (state_d == DSP) || (state_d == RUN);
            rst_n_cpu    <= (state_d == RUN);
            seq_busy     <= (state_d != RUN);
        end
    end

    assign rst_cause = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with an expectation queue.
// Output vector order: periph, dsp, cpu, ack, cause[1:0], busy.
module tb_rst_sequencer;

    logic       clk_54 = 1'b0;
    logic       final_rst;
    logic       soft_rst_req;
    logic       soft_rst_ack;
    logic       wdog_en;
    logic       wdog_kick;
    logic       rst_n_periph;
    logic       rst_n_dsp;
    logic       rst_n_cpu;
    logic [1:0] rst_cause;
    logic       seq_busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        int         at;
        logic [6:0] v;
    } exp_t;

    exp_t sbq[$];

    rst_sequencer #(
        .STRETCH_CYC (16),
        .STAGE_GAP   (8),
        .WDOG_W      (8)
    ) dut (
        .clk_54       (clk_54),
        .final_rst    (final_rst),
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (soft_rst_ack),
        .wdog_en      (wdog_en),
        .wdog_kick    (wdog_kick),
        .rst_n_periph (rst_n_periph),
        .rst_n_dsp    (rst_n_dsp),
        .rst_n_cpu    (rst_n_cpu),
        .rst_cause    (rst_cause),
        .seq_busy     (seq_busy)
    );

    always #5 clk_54 = ~clk_54;

    function automatic logic [6:0] ev(
        input logic p, input logic d, input logic c,
        input logic a, input logic [1:0] cs, input logic b);
        return {p, d, c, a, cs, b};
    endfunction

    function automatic logic [6:0] obs();
        return {rst_n_periph, rst_n_dsp, rst_n_cpu,
                soft_rst_ack, rst_cause, seq_busy};
    endfunction

    task automatic tick();
        @(posedge clk_54);
        #1;
    endtask

    task automatic push(input string tag, input int at,
                        input logic [6:0] v);
        exp_t x;
        x.tag = tag;
        x.at  = at;
        x.v   = v;
        sbq.push_back(x);
    endtask

    task automatic chk_front();
        exp_t x;
        logic [6:0] o;
        x = sbq.pop_front();
        o = obs();
        tests++;
        assert (o === x.v) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", x.tag, o, x.v);
        end
    endtask

    task automatic now(input string tag, input logic [6:0] v);
        push(tag, 0, v);
        chk_front();
    endtask

    // Called just after the edge that put the FSM in HOLD with cnt 0.
    // Expectations are queued up front, then popped at their edge.
    task automatic run_sched(input string tag, input logic [1:0] cs,
                             input int soft_at);
        int pts[8] = '{1, 15, 16, 23, 24, 27, 31, 32};
        foreach (pts[i]) begin
            int e = pts[i];
            push($sformatf("%s_e%0d", tag, e), e,
                 ev(e >= 16, e >= 24, e >= 32, 1'b0, cs, e < 32));
        end
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (soft_at != 0 && e == soft_at) soft_rst_req = 1'b1;
            if (soft_at != 0 && e == soft_at + 1) soft_rst_req = 1'b0;
            while (sbq.size() > 0 && sbq[0].at == e) chk_front();
        end
    endtask

    initial begin
        final_rst    = 1'b1;
        soft_rst_req = 1'b0;
        wdog_en      = 1'b0;
        wdog_kick    = 1'b0;

        repeat (5) tick();
        now("reset", ev(0, 0, 0, 0, 2'b00, 1));
        final_rst = 1'b0;
        run_sched("pwr", 2'b00, 0);

        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        now("soft_hit", ev(0, 0, 0, 1, 2'b01, 1));
        run_sched("soft_dsp", 2'b01, 26);

        wdog_en = 1'b1;
        repeat (255) tick();
        now("wd_pre", ev(1, 1, 1, 0, 2'b01, 0));
        tick();
        now("wd_hit", ev(0, 0, 0, 0, 2'b10, 1));
        run_sched("wdog", 2'b10, 0);

        for (int i = 0; i < 2000; i++) begin
            wdog_kick = (i % 200 == 0);
            tick();
            if (i % 200 == 199)
                now($sformatf("kick_%0d", i),
                    ev(1, 1, 1, 0, 2'b10, 0));
        end
        wdog_kick = 1'b0;

        wdog_kick = 1'b1;
        tick();
        wdog_kick = 1'b0;
        repeat (255) tick();
        wdog_kick = 1'b1;
        tick();
        wdog_kick = 1'b0;
        now("kick_col", ev(1, 1, 1, 0, 2'b10, 0));
        repeat (255) tick();
        now("zero_cnt", ev(1, 1, 1, 0, 2'b10, 0));
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        now("soft_col", ev(0, 0, 0, 1, 2'b01, 1));
        wdog_en = 1'b0;

        repeat (26) tick();
        now("mid_dsp", ev(1, 1, 0, 0, 2'b01, 1));
        #2 final_rst = 1'b1;
        #1 now("arst_dsp", ev(0, 0, 0, 0, 2'b00, 1));
        tick();
        tick();
        final_rst = 1'b0;
        run_sched("re_dsp", 2'b00, 0);

        repeat (3) tick();
        #2 final_rst = 1'b1;
        #1 now("arst_run", ev(0, 0, 0, 0, 2'b00, 1));
        tick();
        final_rst = 1'b0;
        run_sched("re_run", 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
